// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative signed
// shift-add MUL and restoring DIV behind a start/busy/done handshake.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [4:0]         opcode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               done,
    output logic               div_zero
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_SHR  = 5'b00100;
    localparam logic [4:0] OP_SHRA = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_NEG  = 5'b01100;
    localparam logic [4:0] OP_NOT  = 5'b01101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FAST,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [4:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 neg_q, neg_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dz_q, dz_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [SHW-1:0]       amt;
    logic [WIDTH-1:0]     fast_val;
    logic [WIDTH:0]       div_shift, div_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;
    assign amt   = b_q[SHW-1:0];

    // Remainder stays below the divisor, so a negative trial difference means "restore".
    assign div_shift = {rem_q, mplier_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mcand_q[WIDTH-1:0]};

    assign prod_fix = neg_q     ? -acc_q    : acc_q;
    assign quot_fix = neg_q     ? -mplier_q : mplier_q;
    assign rem_fix  = neg_rem_q ? -rem_q    : rem_q;

    always_comb begin
        fast_val = '0;
        case (op_q)
            OP_ADD:  fast_val = a_q + b_q;
            OP_SUB:  fast_val = a_q - b_q;
            OP_SHR:  fast_val = a_q >> amt;
            OP_SHRA: fast_val = $signed(a_q) >>> amt;
            OP_SHL:  fast_val = a_q << amt;
            OP_ROR:  fast_val = (a_q >> amt) | (a_q << (WIDTH - int'(amt)));
            OP_ROL:  fast_val = (a_q << amt) | (a_q >> (WIDTH - int'(amt)));
            OP_AND:  fast_val = a_q & b_q;
            OP_OR:   fast_val = a_q | b_q;
            OP_NEG:  fast_val = -a_q;
            OP_NOT:  fast_val = ~a_q;
            default: fast_val = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        rem_d     = rem_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        case (state_q)
            // DONE accepts like IDLE so a start held with done chains without a gap.
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    op_d      = opcode;
                    a_d       = a;
                    b_d       = b;
                    busy_d    = 1'b1;
                    neg_d     = a[WIDTH-1] ^ b[WIDTH-1];
                    neg_rem_d = a[WIDTH-1];
                    if (opcode == OP_MUL || opcode == OP_DIV) begin
                        state_d = S_ITER;
                        cnt_d   = CW'(WIDTH - 1);
                        acc_d   = '0;
                        rem_d   = '0;
                        if (opcode == OP_MUL) begin
                            mcand_d  = {{WIDTH{1'b0}}, a_mag};
                            mplier_d = b_mag;
                        end else begin
                            mcand_d  = {{WIDTH{1'b0}}, b_mag};
                            mplier_d = a_mag;
                        end
                    end else begin
                        state_d = S_FAST;
                    end
                end
            end
            S_FAST: begin
                result_d = {{WIDTH{1'b0}}, fast_val};
                dz_d     = 1'b0;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_DONE;
            end
            S_ITER: begin
                if (op_q == OP_MUL) begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end else begin
                    if (!div_diff[WIDTH]) begin
                        rem_d    = div_diff[WIDTH-1:0];
                        mplier_d = {mplier_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d    = div_shift[WIDTH-1:0];
                        mplier_d = {mplier_q[WIDTH-2:0], 1'b0};
                    end
                end
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FIX: begin
                dz_d = 1'b0;
                if (op_q == OP_MUL) begin
                    result_d = prod_fix;
                end else if (b_q == '0) begin
                    result_d = {a_q, {WIDTH{1'b1}}};
                    dz_d     = 1'b1;
                end else begin
                    result_d = {rem_fix, quot_fix};
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            rem_q     <= rem_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign result   = result_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule
